// File: rtl/alarm_trigger_ctrl.sv
// Weekday alarm trigger: selects today's alarm word, fires on a minute match, runs the ring/snooze FSM.
// Latency: min_tick in cycle N -> ringing/buzzer high in cycle N+1; all outputs registered.
// No backpressure: button edges and ticks act the cycle they arrive. Optional: ALARM_BEEP_PATTERN_EN.
module alarm_trigger_ctrl #(
    parameter int unsigned SNOOZE_MIN     = 9,
    parameter int unsigned RING_TIMEOUT_S = 60,
    parameter int unsigned MAX_SNOOZE     = 3
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic [12:0] Q_r0,
    input  logic [12:0] Q_r1,
    input  logic [12:0] Q_r2,
    input  logic [12:0] Q_r3,
    input  logic [12:0] Q_r4,
    input  logic [12:0] Q_r5,
    input  logic [12:0] Q_r6,
    input  logic [2:0]  day,
    input  logic [5:0]  cur_hour,
    input  logic [5:0]  cur_min,
    input  logic        min_tick,
    input  logic        sec_tick,
    input  logic        snooze,
    input  logic        stop,
    output logic        buzzer,
    output logic        ringing,
    output logic        snoozing,
    output logic [1:0]  snooze_left
);

    localparam logic [8:0] TIMEOUT_W  = 9'(RING_TIMEOUT_S);
    localparam logic [5:0] SNZ_MIN_W  = 6'(SNOOZE_MIN);
    localparam logic [1:0] MAX_SNZ_W  = 2'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RING   = 2'd1,
        S_SNOOZE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [12:0] sel;
    logic        match;
    logic        snooze_q, stop_q;
    logic        snooze_edge, stop_edge;
    logic [7:0]  ring_cnt, ring_cnt_nxt;
    logic [5:0]  snz_cnt, snz_cnt_nxt;
    logic [1:0]  snooze_left_nxt;
    logic        buzzer_nxt;
    logic        timeout_hit;

    // Pick the alarm word for today; an invalid weekday yields a disabled word.
    always_comb begin
        sel = 13'd0;
        case (day)
            3'd0:    sel = Q_r0;
            3'd1:    sel = Q_r1;
            3'd2:    sel = Q_r2;
            3'd3:    sel = Q_r3;
            3'd4:    sel = Q_r4;
            3'd5:    sel = Q_r5;
            3'd6:    sel = Q_r6;
            default: sel = 13'd0;
        endcase
    end

    assign match       = sel[12] && (sel[11:6] == cur_hour) && (sel[5:0] == cur_min);
    assign snooze_edge = snooze && !snooze_q;
    assign stop_edge   = stop && !stop_q;
    // The tick that would bring the ring counter up to the limit ends the ring on that same edge.
    assign timeout_hit = sec_tick && (({1'b0, ring_cnt} + 9'd1) == TIMEOUT_W);

    // Button history for rising-edge detection.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            snooze_q <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            snooze_q <= snooze;
            stop_q   <= stop;
        end
    end

    // Next-state, counters and buzzer; stop beats snooze, both beat the ring timeout.
    always_comb begin
        state_nxt       = state;
        ring_cnt_nxt    = ring_cnt;
        snz_cnt_nxt     = snz_cnt;
        snooze_left_nxt = snooze_left;
        buzzer_nxt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (min_tick && match) begin
                    state_nxt       = S_RING;
                    ring_cnt_nxt    = 8'd0;
                    snooze_left_nxt = MAX_SNZ_W;
                end
            end
            S_RING: begin
                if (stop_edge) begin
                    state_nxt = S_IDLE;
                end else if (snooze_edge) begin
                    if (snooze_left != 2'd0) begin
                        state_nxt       = S_SNOOZE;
                        snooze_left_nxt = snooze_left - 2'd1;
                        snz_cnt_nxt     = SNZ_MIN_W;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end else if (sec_tick) begin
                    ring_cnt_nxt = ring_cnt + 8'd1;
                end
            end
            S_SNOOZE: begin
                if (stop_edge) begin
                    state_nxt = S_IDLE;
                end else if (min_tick) begin
                    if (snz_cnt <= 6'd1) begin
                        state_nxt    = S_RING;
                        ring_cnt_nxt = 8'd0;
                        snz_cnt_nxt  = 6'd0;
                    end else begin
                        snz_cnt_nxt = snz_cnt - 6'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
`ifdef ALARM_BEEP_PATTERN_EN
        // Beep: start on at ring entry, flip each second while ringing.
        if (state_nxt != S_RING)
            buzzer_nxt = 1'b0;
        else if (state != S_RING)
            buzzer_nxt = 1'b1;
        else if (sec_tick)
            buzzer_nxt = !buzzer;
        else
            buzzer_nxt = buzzer;
`else
        buzzer_nxt = (state_nxt == S_RING);
`endif
    end

    // State, counters and registered outputs; Clr low clears everything at once.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state       <= S_IDLE;
            ring_cnt    <= 8'd0;
            snz_cnt     <= 6'd0;
            snooze_left <= MAX_SNZ_W;
            buzzer      <= 1'b0;
            ringing     <= 1'b0;
            snoozing    <= 1'b0;
        end else begin
            state       <= state_nxt;
            ring_cnt    <= ring_cnt_nxt;
            snz_cnt     <= snz_cnt_nxt;
            snooze_left <= snooze_left_nxt;
            buzzer      <= buzzer_nxt;
            ringing     <= (state_nxt == S_RING);
            snoozing    <= (state_nxt == S_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_trigger_ctrl.sv
// Bench for alarm_trigger_ctrl: vector table for selection/match, directed ring/snooze/reset
// sequences, then random stimulus against a behavioural model. Honours ALARM_BEEP_PATTERN_EN.
// Summary line reports passed/total comparisons.
module tb_alarm_trigger_ctrl;

    localparam int SNZ_MIN  = 9;
    localparam int TIMEOUT  = 60;
    localparam int MAX_SNZ  = 3;
`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit BEEP = 1'b1;
`else
    localparam bit BEEP = 1'b0;
`endif
    localparam logic [12:0] W0730 = 13'b1_000111_011110;

    logic        Clk, Clr;
    logic [12:0] q [7];
    logic [2:0]  day;
    logic [5:0]  cur_hour, cur_min;
    logic        min_tick, sec_tick, snooze, stop;
    logic        buzzer, ringing, snoozing;
    logic [1:0]  snooze_left;

    int n_checks = 0;
    int n_pass   = 0;

    alarm_trigger_ctrl #(.SNOOZE_MIN(SNZ_MIN), .RING_TIMEOUT_S(TIMEOUT), .MAX_SNOOZE(MAX_SNZ)) dut (
        .Clk(Clk), .Clr(Clr),
        .Q_r0(q[0]), .Q_r1(q[1]), .Q_r2(q[2]), .Q_r3(q[3]), .Q_r4(q[4]), .Q_r5(q[5]), .Q_r6(q[6]),
        .day(day), .cur_hour(cur_hour), .cur_min(cur_min),
        .min_tick(min_tick), .sec_tick(sec_tick), .snooze(snooze), .stop(stop),
        .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing), .snooze_left(snooze_left)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 7; i++) q[i] = 13'd0;
        day = 3'd0; cur_hour = 6'd0; cur_min = 6'd0;
        min_tick = 1'b0; sec_tick = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        Clr = 1'b0;
        repeat (2) step();
        Clr = 1'b1;
        step();
    endtask

    task automatic pulse_min();
        min_tick = 1'b1; step(); min_tick = 1'b0;
    endtask

    task automatic press_snooze();
        snooze = 1'b1; step(); snooze = 1'b0; step();
    endtask

    task automatic press_stop();
        stop = 1'b1; step(); stop = 1'b0; step();
    endtask

    // Arms Q_r2 at 07:30 on Tuesday and fires it.
    task automatic trigger(input string name);
        q[2] = W0730; day = 3'd2; cur_hour = 6'd7; cur_min = 6'd30;
        pulse_min();
        check(name, ringing, 1);
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_RING, M_SNOOZE} mmode_t;
    mmode_t m_mode;
    int     m_secs, m_mins, m_left;
    bit     m_beep, m_prev_snz, m_prev_stp;

    task automatic model_reset();
        m_mode = M_IDLE; m_secs = 0; m_mins = 0; m_left = MAX_SNZ; m_beep = 0;
        m_prev_snz = 0; m_prev_stp = 0;
    endtask

    // One clock of the alarm rules, using the inputs about to be sampled.
    task automatic model_clock();
        bit snz_e, stp_e, hit;
        logic [12:0] w;
        snz_e = snooze && !m_prev_snz;
        stp_e = stop && !m_prev_stp;
        m_prev_snz = snooze;
        m_prev_stp = stop;
        w = (day < 3'd7) ? q[day] : 13'd0;
        hit = w[12] && (int'(w[11:6]) == int'(cur_hour)) && (int'(w[5:0]) == int'(cur_min));
        case (m_mode)
            M_IDLE: if (min_tick && hit) begin
                m_mode = M_RING; m_secs = 0; m_left = MAX_SNZ; m_beep = 1;
            end
            M_RING: begin
                if (stp_e) m_mode = M_IDLE;
                else if (snz_e) begin
                    if (m_left > 0) begin m_left--; m_mins = SNZ_MIN; m_mode = M_SNOOZE; end
                    else m_mode = M_IDLE;
                end else if (sec_tick) begin
                    m_secs++; m_beep = !m_beep;
                    if (m_secs == TIMEOUT) m_mode = M_IDLE;
                end
            end
            default: begin
                if (stp_e) m_mode = M_IDLE;
                else if (min_tick) begin
                    m_mins--;
                    if (m_mins == 0) begin m_mode = M_RING; m_secs = 0; m_beep = 1; end
                end
            end
        endcase
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          slot;
        bit          all;
        logic [12:0] word;
        logic [2:0]  d;
        logic [5:0]  hh;
        logic [5:0]  mm;
        bit          exp_ring;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int exp_buz;
        Clr = 1'b1;
        clear_inputs();
        #1 Clr = 1'b0;
        #2;
        check("reset_buzzer", buzzer, 0);
        check("reset_ringing", ringing, 0);
        check("reset_snoozing", snoozing, 0);
        check("reset_snooze_left", snooze_left, MAX_SNZ);
        repeat (2) step();
        Clr = 1'b1;
        step();

        tbl[0] = '{"match_tue_0730",   2, 0, W0730,               3'd2, 6'd7,  6'd30, 1};
        tbl[1] = '{"disabled_word",    2, 0, 13'b0_000111_011110, 3'd2, 6'd7,  6'd30, 0};
        tbl[2] = '{"wrong_day",        2, 0, W0730,               3'd3, 6'd7,  6'd30, 0};
        tbl[3] = '{"day7_invalid",     0, 1, W0730,               3'd7, 6'd7,  6'd30, 0};
        tbl[4] = '{"minute_off",       2, 0, W0730,               3'd2, 6'd7,  6'd31, 0};
        tbl[5] = '{"hour_off",         2, 0, W0730,               3'd2, 6'd8,  6'd30, 0};
        tbl[6] = '{"sat_2359",         6, 0, 13'b1_010111_111011, 3'd6, 6'd23, 6'd59, 1};
        tbl[7] = '{"sun_0000",         0, 0, 13'b1_000000_000000, 3'd0, 6'd0,  6'd0,  1};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (tbl[i].all) for (int k = 0; k < 7; k++) q[k] = tbl[i].word;
            else q[tbl[i].slot] = tbl[i].word;
            day = tbl[i].d; cur_hour = tbl[i].hh; cur_min = tbl[i].mm;
            check({tbl[i].name, "_no_ring_before_tick"}, ringing, 0);
            pulse_min();
            check({tbl[i].name, "_ringing"}, ringing, int'(tbl[i].exp_ring));
            check({tbl[i].name, "_buzzer"}, buzzer, int'(tbl[i].exp_ring));
        end

        // Ring timeout after 60 seconds, with beep pattern check on the first ticks.
        do_reset();
        trigger("to_trigger");
        check("to_buzzer_entry", buzzer, 1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            sec_tick = 1'b1; step(); sec_tick = 1'b0;
            if (i <= 4) begin
                exp_buz = BEEP ? int'(i % 2 == 0) : 1;
                check($sformatf("to_buzzer_tick%0d", i), buzzer, exp_buz);
                check($sformatf("to_ringing_tick%0d", i), ringing, 1);
            end
            if (i == TIMEOUT - 1) check("to_still_ringing_59", ringing, 1);
        end
        check("to_ringing_after_60", ringing, 0);
        check("to_buzzer_after_60", buzzer, 0);

        // Snooze chain down to zero, then one more snooze acts as stop.
        do_reset();
        trigger("sz_trigger");
        for (int k = 0; k < MAX_SNZ; k++) begin
            press_snooze();
            check($sformatf("sz%0d_snoozing", k), snoozing, 1);
            check($sformatf("sz%0d_buzzer", k), buzzer, 0);
            check($sformatf("sz%0d_left", k), snooze_left, MAX_SNZ - 1 - k);
            if (k == 0) begin
                press_snooze();
                check("sz_ignored_left", snooze_left, MAX_SNZ - 1);
                check("sz_ignored_snoozing", snoozing, 1);
            end
            for (int j = 1; j <= SNZ_MIN; j++) begin
                pulse_min();
                if (j == SNZ_MIN - 1) check($sformatf("sz%0d_still_snoozing", k), snoozing, 1);
            end
            check($sformatf("sz%0d_rering", k), ringing, 1);
            check($sformatf("sz%0d_rering_buzzer", k), buzzer, 1);
        end
        press_snooze();
        check("sz_exhausted_ringing", ringing, 0);
        check("sz_exhausted_snoozing", snoozing, 0);
        check("sz_exhausted_left", snooze_left, 0);

        // Stop and snooze in the same clock: stop wins.
        do_reset();
        trigger("both_trigger");
        snooze = 1'b1; stop = 1'b1; step(); snooze = 1'b0; stop = 1'b0;
        check("both_ringing", ringing, 0);
        check("both_snoozing", snoozing, 0);
        check("both_left", snooze_left, MAX_SNZ);

        // Stopped alarm stays quiet without a fresh minute tick, then fires on one.
        do_reset();
        trigger("rt_trigger");
        press_stop();
        repeat (5) step();
        check("rt_quiet", ringing, 0);
        pulse_min();
        check("rt_fresh_tick", ringing, 1);

        // Asynchronous clear mid-snooze and mid-ring.
        do_reset();
        trigger("clr_trigger");
        press_snooze();
        check("clr_pre_snoozing", snoozing, 1);
        #2 Clr = 1'b0;
        #1;
        check("clr_snoozing", snoozing, 0);
        check("clr_left", snooze_left, MAX_SNZ);
        check("clr_ringing", ringing, 0);
        step(); Clr = 1'b1; step();
        trigger("clr2_trigger");
        #2 Clr = 1'b0;
        #1;
        check("clr_ring_buzzer", buzzer, 0);
        check("clr_ring_ringing", ringing, 0);
        step(); Clr = 1'b1; step();

        // Random stimulus against the model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 40 == 0) begin
                for (int k = 0; k < 7; k++) begin
                    case ($urandom_range(0, 3))
                        0: q[k] = W0730;
                        1: q[k] = 13'b0_000111_011110;
                        2: q[k] = 13'b1_000111_011111;
                        default: q[k] = 13'($urandom);
                    endcase
                end
                day = 3'($urandom_range(0, 7));
                cur_hour = 6'd7;
                cur_min = ($urandom_range(0, 1) == 0) ? 6'd30 : 6'd31;
            end
            min_tick = ($urandom_range(0, 7) == 0);
            sec_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) snooze = !snooze;
            if ($urandom_range(0, 29) == 0) stop = !stop;
            model_clock();
            step();
            check("rnd_ringing", ringing, int'(m_mode == M_RING));
            check("rnd_snoozing", snoozing, int'(m_mode == M_SNOOZE));
            check("rnd_buzzer", buzzer, int'(m_mode == M_RING && (!BEEP || m_beep)));
            check("rnd_left", snooze_left, m_left);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
